// File: rtl/cone_sched_pkg.sv
// Shared FSM encoding and operand-field constants for the cone evaluation scheduler.
package cone_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int OP_W   = 5;
    localparam int N0_BIT = 0;
    localparam int N1_BIT = 1;
    localparam int N2_BIT = 2;
    localparam int N3_BIT = 3;
    localparam int N4_BIT = 4;

endpackage

// File: rtl/cone_eval_unit.sv
// Combinational 5-input timing cone: NAND2(n4,n3) and NOR2(n1,n0) feed an AOI21
// whose OR leg is INV(n2), giving Y = ~((~(n4&n3) & ~(n1|n0)) | ~n2).
module cone_eval_unit
    import cone_sched_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output logic            y
);

    logic nand_n43;
    logic nor_n10;
    logic inv_n2;

    assign nand_n43 = ~(op[N4_BIT] & op[N3_BIT]);
    assign nor_n10  = ~(op[N1_BIT] | op[N0_BIT]);
    assign inv_n2   = ~op[N2_BIT];
    assign y        = ~((nand_n43 & nor_n10) | inv_n2);

endmodule

// File: rtl/cone_eval_scheduler.sv
// Round-robin scheduler sharing one cone_eval_unit among NUM_REQ requesters.
// Defining CONE_EVAL_STATS_EN adds per-requester saturating grant counters (grant_cnt).
module cone_eval_scheduler
    import cone_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
`ifdef CONE_EVAL_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_op,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_data,
    output logic                    busy
`ifdef CONE_EVAL_STATS_EN
    , output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            rsp_data_q, rsp_data_d;
    logic            cone_y;

    logic [NUM_REQ-1:0] valid_rot;
    logic [ID_W-1:0]    pick_rot;
    logic [ID_W:0]      grant_sum;
    logic [ID_W-1:0]    grant_idx;
    logic               any_valid;
    logic               grant_fire;

    // Rotate so rr_ptr sits at bit 0, pick the lowest set bit, then rotate the index back.
    assign valid_rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
    assign any_valid = |req_valid;

    always_comb begin
        pick_rot = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid_rot[i]) pick_rot = ID_W'(i);
        end
    end

    assign grant_sum  = {1'b0, pick_rot} + {1'b0, rr_ptr_q};
    assign grant_idx  = (grant_sum >= NUM_REQ_W) ? ID_W'(grant_sum - NUM_REQ_W)
                                                 : grant_sum[ID_W-1:0];
    assign grant_fire = (state_q == IDLE) && any_valid;

    cone_eval_unit u_cone (
        .op (op_q),
        .y  (cone_y)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_id_d   = rsp_id_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready[grant_idx] = 1'b1;
                    op_d                 = req_op[grant_idx*OP_W +: OP_W];
                    rsp_id_d             = grant_idx;
                    rr_ptr_d             = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                    state_d              = EVAL;
                end
            end
            EVAL: begin
                rsp_data_d = cone_y;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments only; the operand register is reset too so
    // the cone never sees X after reset, even though its value is unused until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            op_q       <= '0;
            rsp_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_id_q   <= rsp_id_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

`ifdef CONE_EVAL_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (grant_fire && (grant_cnt_q[grant_idx] != '1)) begin
            grant_cnt_d[grant_idx] = grant_cnt_q[grant_idx] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) grant_cnt_q <= '0;
        else     grant_cnt_q <= grant_cnt_d;
    end

    assign grant_cnt = grant_cnt_q;
`else
    logic unused_grant_fire;
    assign unused_grant_fire = grant_fire;
`endif

endmodule
